// File: rtl/serial_add_controller_pkg.sv
// Shared definitions for the serial add controller: default widths,
// state encoding and the step codes shown to the operator.
// Optional feature macro used by the top: ADD_SUB_EN.
package serial_add_controller_pkg;

  localparam int WIDTH_DEF       = 7;
  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [2:0] S_LOAD_XL = 3'd0;
  localparam logic [2:0] S_LOAD_XH = 3'd1;
  localparam logic [2:0] S_LOAD_YL = 3'd2;
  localparam logic [2:0] S_LOAD_YH = 3'd3;
  localparam logic [2:0] S_ADD     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  typedef enum logic [2:0] {
    ST_LOAD_XL = S_LOAD_XL,
    ST_LOAD_XH = S_LOAD_XH,
    ST_LOAD_YL = S_LOAD_YL,
    ST_LOAD_YH = S_LOAD_YH,
    ST_ADD     = S_ADD,
    ST_DONE    = S_DONE
  } state_e;

  localparam logic [1:0] STEP_XL = 2'd0;
  localparam logic [1:0] STEP_XH = 2'd1;
  localparam logic [1:0] STEP_YL = 2'd2;
  localparam logic [1:0] STEP_YH = 2'd3;

endpackage

// File: rtl/serial_add_controller_full_adder.sv
// Single-bit full adder cell, time-shared by the serial adder.
// Ports: a, b, cin in; sum, cout out.
module serial_add_controller_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_controller.sv
// Serial add controller: captures X low/high and Y low/high nibbles from a
// switch bank on debounced-edge ENTER presses, then adds X+Y one bit per
// cycle through a single full adder and holds the result.
// Ports:
//   clk, rst (sync, active-high), pb (async ENTER), a[3:0] nibble switches,
//   sub (only with ADD_SUB_EN: 1 = subtract, sampled on the YH press),
//   z[WIDTH-1:0] result, carry, done, busy, step[1:0] next nibble expected.
// Build option: define ADD_SUB_EN to add the subtract mode and sub port.
//
// state    | meaning
// LOAD_XL  | waiting for X low nibble
// LOAD_XH  | waiting for X high nibble (a[3] ignored)
// LOAD_YL  | waiting for Y low nibble
// LOAD_YH  | waiting for Y high nibble; press starts the add
// ADD      | one result bit per cycle, presses ignored
// DONE     | result held; next press is the X low capture
module serial_add_controller
  import serial_add_controller_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pb,
  input  logic [3:0]       a,
`ifdef ADD_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             done,
  output logic             busy,
  output logic [1:0]       step
);

  localparam int IW = $clog2(WIDTH);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [WIDTH-1:0]       x_q, x_d, y_q, y_d, s_q, s_d, z_q, z_d;
  logic                   c_q, c_d, carry_q, carry_d, done_q, done_d, busy_q, busy_d;
  logic [IW-1:0]          i_q, i_d;
  logic                   enter, sub_eff, fa_b, fa_cin, fa_sum, fa_cout;

`ifdef ADD_SUB_EN
  logic sub_q, sub_d;
  assign sub_eff = sub_q;
`else
  assign sub_eff = 1'b0;
`endif

  assign enter = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Subtraction is x + ~y + 1: invert y and seed the carry with sub.
  assign fa_b   = y_q[i_q] ^ sub_eff;
  assign fa_cin = (i_q == '0) ? sub_eff : c_q;

  serial_add_controller_full_adder u_fa (
    .a    (x_q[i_q]),
    .b    (fa_b),
    .cin  (fa_cin),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[SYNC_STAGES-2:0], pb};
    prev_d  = sync_q[SYNC_STAGES-1];
    x_d     = x_q;
    y_d     = y_q;
    s_d     = s_q;
    z_d     = z_q;
    c_d     = c_q;
    carry_d = carry_q;
    done_d  = done_q;
    busy_d  = busy_q;
    i_d     = i_q;
`ifdef ADD_SUB_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      // DONE shares the X low capture; it is also where the old result is cleared.
      ST_LOAD_XL, ST_DONE: if (enter) begin
        x_d[3:0] = a;
        z_d      = '0;
        carry_d  = 1'b0;
        done_d   = 1'b0;
        state_d  = ST_LOAD_XH;
      end
      ST_LOAD_XH: if (enter) begin
        x_d[WIDTH-1:4] = a[WIDTH-5:0];
        state_d        = ST_LOAD_YL;
      end
      ST_LOAD_YL: if (enter) begin
        y_d[3:0] = a;
        state_d  = ST_LOAD_YH;
      end
      ST_LOAD_YH: if (enter) begin
        y_d[WIDTH-1:4] = a[WIDTH-5:0];
`ifdef ADD_SUB_EN
        sub_d          = sub;
`endif
        busy_d         = 1'b1;
        i_d            = '0;
        state_d        = ST_ADD;
      end
      ST_ADD: begin
        s_d[i_q] = fa_sum;
        c_d      = fa_cout;
        if (i_q == IW'(WIDTH - 1)) begin
          z_d     = s_d;
          carry_d = fa_cout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      default: state_d = ST_LOAD_XL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD_XL;
      // Sync chain and prev start high so a button held through reset is not an edge.
      sync_q  <= '1;
      prev_q  <= 1'b1;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      z_q     <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      i_q     <= '0;
`ifdef ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      x_q     <= x_d;
      y_q     <= y_d;
      s_q     <= s_d;
      z_q     <= z_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      i_q     <= i_d;
`ifdef ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  always_comb begin
    step = STEP_XL;
    unique case (state_q)
      ST_LOAD_XH: step = STEP_XH;
      ST_LOAD_YL: step = STEP_YL;
      ST_LOAD_YH: step = STEP_YH;
      default:    step = STEP_XL;
    endcase
  end

  assign z     = z_q;
  assign carry = carry_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_serial_add_controller.sv
module tb_serial_add_controller;

  logic       clk = 1'b0;
  logic       rst, pb, sub;
  logic [3:0] a;
  logic [6:0] z;
  logic       carry, done, busy;
  logic [1:0] step;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_controller dut (
    .clk   (clk),
    .rst   (rst),
    .pb    (pb),
    .a     (a),
`ifdef ADD_SUB_EN
    .sub   (sub),
`endif
    .z     (z),
    .carry (carry),
    .done  (done),
    .busy  (busy),
    .step  (step)
  );

  typedef struct {
    logic [3:0] n0, n1, n2, n3;
    bit         sb;
    int         ez, ec;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: operands from nibbles, then plain integer arithmetic.
  task automatic model(input logic [3:0] n0, n1, n2, n3, input bit sb,
                       output int ez, output int ec);
    int x, y, t;
    x = n0 + 16 * (n1 % 8);
    y = n2 + 16 * (n3 % 8);
    if (sb) t = x - y + 128;
    else    t = x + y;
    ez = t % 128;
    ec = t / 128;
  endtask

  task automatic press(input logic [3:0] nib, input int hold);
    a  = nib;
    pb = 1'b1;
    repeat (hold) @(negedge clk);
    pb = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // YH press; measures cycles from pb rise to done, optionally pulsing pb during ADD.
  task automatic do_yh(input logic [3:0] nib, input bit pulses);
    int  lat;
    bit  partial;
    a       = nib;
    pb      = 1'b1;
    lat     = -1;
    partial = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (lat < 0 && done) lat = k;
      if (!done && z != 0) partial = 1;
      if (k == 2) pb = 1'b0;
      if (pulses && (k == 3 || k == 5 || k == 7)) pb = 1'b1;
      if (pulses && (k == 4 || k == 6 || k == 8)) pb = 1'b0;
      if (k == 6) chk("busy_mid_add", busy, 1);
    end
    chk("done_latency", lat, 10);
    chk("no_partial_z", partial, 0);
  endtask

  task automatic run_op(input logic [3:0] n0, n1, n2, n3, input bit sb,
                        input int ez, input int ec, input bit pulses);
    press(n0, 1 + $urandom_range(0, 3));
    chk("step_after_xl", step, 1);
    chk("done_cleared", done, 0);
    chk("z_cleared", z, 0);
    chk("carry_cleared", carry, 0);
    press(n1, 1 + $urandom_range(0, 3));
    chk("step_after_xh", step, 2);
    press(n2, 1 + $urandom_range(0, 3));
    chk("step_after_yl", step, 3);
    sub = sb;
    do_yh(n3, pulses);
    sub = 1'b0;
    chk("z", z, ez);
    chk("carry", carry, ec);
    chk("done", done, 1);
    chk("busy_after", busy, 0);
    chk("step_after_done", step, 0);
  endtask

  initial begin
    int ez, ec;
    rst = 1'b1; pb = 1'b0; a = 4'h0; sub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_z", z, 0);
    chk("rst_carry", carry, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step", step, 0);

    vecs.push_back('{n0: 4'h9, n1: 4'h1, n2: 4'h5, n3: 4'h2, sb: 0, ez: 62,  ec: 0});
    vecs.push_back('{n0: 4'hF, n1: 4'h7, n2: 4'h1, n3: 4'h0, sb: 0, ez: 0,   ec: 1});
    vecs.push_back('{n0: 4'hF, n1: 4'hF, n2: 4'hF, n3: 4'hF, sb: 0, ez: 126, ec: 1});
    vecs.push_back('{n0: 4'h0, n1: 4'h0, n2: 4'h0, n3: 4'h0, sb: 0, ez: 0,   ec: 0});
    vecs.push_back('{n0: 4'h3, n1: 4'h4, n2: 4'hD, n3: 4'h2, sb: 0, ez: 112, ec: 0});
`ifdef ADD_SUB_EN
    vecs.push_back('{n0: 4'h5, n1: 4'h2, n2: 4'h9, n3: 4'h1, sb: 1, ez: 12,  ec: 1});
    vecs.push_back('{n0: 4'h9, n1: 4'h1, n2: 4'h5, n3: 4'h2, sb: 1, ez: 116, ec: 0});
    vecs.push_back('{n0: 4'h4, n1: 4'h3, n2: 4'h4, n3: 4'h3, sb: 1, ez: 0,   ec: 1});
`endif
    foreach (vecs[v])
      run_op(vecs[v].n0, vecs[v].n1, vecs[v].n2, vecs[v].n3, vecs[v].sb,
             vecs[v].ez, vecs[v].ec, 0);

    // Presses during ADD are ignored and not queued.
    run_op(4'h9, 4'h1, 4'h5, 4'h2, 0, 62, 0, 1);
    repeat (10) @(negedge clk);
    chk("no_queued_step", step, 0);
    chk("held_z", z, 62);
    chk("held_done", done, 1);

    // Reset while DONE holds a nonzero result.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_done_z", z, 0);
    chk("rst_done_done", done, 0);
    chk("rst_done_carry", carry, 0);

    // Reset mid-ADD at i=3, pb held high through and after reset.
    press(4'h1, 1); press(4'h2, 1); press(4'h3, 1);
    a = 4'h4; pb = 1'b1;
    repeat (2) @(negedge clk);
    pb = 1'b0;
    repeat (4) @(negedge clk);
    pb = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("midadd_z", z, 0);
    chk("midadd_carry", carry, 0);
    chk("midadd_done", done, 0);
    chk("midadd_busy", busy, 0);
    chk("midadd_step", step, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("held_through_rst_step", step, 0);
    pb = 1'b0;
    repeat (4) @(negedge clk);
    chk("release_after_rst_step", step, 0);

    // Button held 1000 cycles captures exactly one nibble.
    a = 4'h6; pb = 1'b1;
    repeat (1000) @(negedge clk);
    chk("long_hold_step", step, 1);
    pb = 1'b0;
    repeat (4) @(negedge clk);
    chk("long_release_step", step, 1);
    press(4'h2, 1); press(4'h8, 1);
    do_yh(4'h1, 0);
    model(4'h6, 4'h2, 4'h8, 4'h1, 0, ez, ec);
    chk("long_hold_z", z, ez);
    chk("long_hold_carry", carry, ec);

    // Randomised operands against the arithmetic model.
    for (int r = 0; r < 25; r++) begin
      logic [3:0] n0, n1, n2, n3;
      bit sb;
      n0 = 4'($urandom); n1 = 4'($urandom);
      n2 = 4'($urandom); n3 = 4'($urandom);
`ifdef ADD_SUB_EN
      sb = 1'($urandom);
`else
      sb = 0;
`endif
      model(n0, n1, n2, n3, sb, ez, ec);
      run_op(n0, n1, n2, n3, sb, ez, ec, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
